uart_cmd_ctrl: RTL
==================

// Module: uart_cmd_ctrl
// PURPOSE
//  Frame controller downstream of the UART receiver inside ctrl_top.
//  - Consumes the received byte stream (data byte plus one-cycle done pulse) and parses fixed 5-byte command frames:
//    0xAA header, CMD, ADDR, DATA, CSUM.
//  - Issues register write/read requests to the control fabric.
//  - Flags checksum, command and inter-byte timeout errors.
// PARAMETERS
//  HEADER      8'hAA   frame start byte
//  CMD_WR      8'h01   write command code
//  CMD_RD      8'h02   read command code
//  TIMEOUT     52080   max s_clk cycles between bytes inside a frame (10 bit times at 9600 baud / 50 MHz)
//  TO_W        16      timeout counter width; TIMEOUT < 2**TO_W
// PORTS
//  s_clk        in   1  system clock, 50 MHz
//  s_rst        in   1  synchronous reset, active high
//  rx_data      in   8  received byte, valid while rx_flag=1
//  rx_flag      in   1  one-cycle pulse: rx_data holds a new byte
//  cmd_wr       out  1  one-cycle write request pulse
//  cmd_rd       out  1  one-cycle read request pulse
//  cmd_addr     out  8  register address; held until the next valid frame
//  cmd_data     out  8  write data; held until the next valid frame (read frames update it too)
//  err_csum     out  1  one-cycle pulse: checksum mismatch
//  err_cmd      out  1  one-cycle pulse: checksum ok, CMD not WR/RD
//  err_timeout  out  1  one-cycle pulse: inter-byte gap exceeded TIMEOUT
//  busy         out  1  1 while state != IDLE
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, all outputs 0, sum=0, timer=0. Reset mid-frame discards the partial frame
//    without any error pulse.
//  - States: IDLE -> CMD -> ADDR -> DATA -> CSUM -> IDLE. Each advance consumes exactly one rx_flag.
//  - IDLE: rx_flag with rx_data==HEADER -> CMD and clear sum. Any other byte is ignored silently.
//  - CMD/ADDR/DATA: latch the byte into a shadow register and sum <= sum + rx_data (8-bit, wraps mod 256).
//    The header is not summed.
//  - CSUM: on rx_flag, compare rx_data with sum, then return to IDLE.
//    - Match and CMD==CMD_WR: cmd_wr=1.
//    - Match and CMD==CMD_RD: cmd_rd=1.
//    - Match, other CMD: err_cmd=1.
//    - Mismatch: err_csum=1, regardless of CMD.
//    - cmd_addr/cmd_data update from the shadow registers only on a match with a valid CMD, in the same cycle as
//      the pulse.
//  - Latency: the response pulse is registered and asserts on the cycle after the CSUM-byte rx_flag; width is
//    exactly 1 cycle.
//  - Timeout timer:
//    - Cleared on every rx_flag and held at 0 in IDLE.
//    - Increments every cycle in states CMD..CSUM.
//    - When timer==TIMEOUT-1 with no rx_flag: state -> IDLE, err_timeout pulses for 1 cycle, timer clears.
//    - Simultaneous rx_flag and expiry: rx_flag wins; the byte is processed and no timeout is raised.
//  - A header byte seen in CMD..CSUM is treated as ordinary data (no resync). Resync happens only through timeout
//    or checksum failure.
//  - Outputs are mutually exclusive: at most one of cmd_wr/cmd_rd/err_* high in any cycle.
//  - busy mirrors the registered state; it is 0 in the cycle the response pulse is high.
// STRUCTURE
//  - Package uart_cmd_pkg holds:
//    - state encoding constants ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_CSUM (3-bit);
//    - HEADER, CMD_WR, CMD_RD defaults.
//  - One sub-module, uart_gap_timer (params TIMEOUT, TO_W).
//    - Inputs: clr, en. Output: expire pulse.
//    - Instantiated once; the FSM, checksum accumulator and output registers live in uart_cmd_ctrl.
// TESTING
//  - Write frame AA 01 10 5A 6B, bytes 10 clks apart -> one cmd_wr pulse, cmd_addr=10h, cmd_data=5Ah, no err_*.
//  - Read frame AA 02 33 00 35 -> cmd_rd pulse, cmd_addr=33h; then AA 01 80 90 00 (sum wraps 111h->11h,
//    CSUM 00 wrong) -> err_csum, cmd_addr stays 33h.
//  - Frame AA 07 01 02 0A -> err_cmd pulse, no cmd_wr/cmd_rd, cmd_addr/cmd_data unchanged.
//  - Send AA 01 10, then idle -> err_timeout exactly TIMEOUT cycles after the 10h rx_flag, busy=0.
//    Following full frame AA 01 10 5A 6B is accepted.
//  - Gap exactly TIMEOUT-1 cycles with rx_flag on the expiry cycle -> no err_timeout, frame completes.
//    Garbage 55 FF before AA is ignored.
//  - Assert s_rst after AA 01 10 -> all outputs 0 next cycle.
//    Then bytes 5A 6B alone produce no pulse; a full new frame is accepted.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared encodings for the UART command frame controller.
// Holds the state codes and the default frame byte values.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    localparam logic [7:0] HEADER = 8'hAA;
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts idle cycles inside a frame.
// expire pulses when the count reaches TIMEOUT-1 without a new byte.
module uart_gap_timer #(
    parameter int TIMEOUT = 52080,
    parameter int TO_W    = 16
) (
    input  logic s_clk,
    input  logic s_rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TO_W-1:0] TERM = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] timer_q;

    // A byte arriving on the terminal cycle takes priority over expiry.
    assign expire = en && !clr && (timer_q == TERM);

    always_ff @(posedge s_clk) begin
        if (s_rst || clr || !en || expire)
            timer_q <= '0;
        else
            timer_q <= timer_q + TO_W'(1);
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses 5-byte AA/CMD/ADDR/DATA/CSUM frames from the UART receiver and
// issues register write/read requests or error pulses.
//
// state   | meaning
// --------+------------------------------------------
// IDLE    | hunting for the header byte
// CMD     | waiting for the command byte
// ADDR    | waiting for the address byte
// DATA    | waiting for the data byte
// CSUM    | waiting for the checksum, then respond
module uart_cmd_ctrl #(
    parameter logic [7:0] HEADER  = uart_cmd_pkg::HEADER,
    parameter logic [7:0] CMD_WR  = uart_cmd_pkg::CMD_WR,
    parameter logic [7:0] CMD_RD  = uart_cmd_pkg::CMD_RD,
    parameter int         TIMEOUT = 52080,
    parameter int         TO_W    = 16
) (
    input  logic       s_clk,
    input  logic       s_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_flag,
    output logic       cmd_wr,
    output logic       cmd_rd,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic       err_csum,
    output logic       err_cmd,
    output logic       err_timeout,
    output logic       busy
);

    import uart_cmd_pkg::*;

    state_t     state_q, state_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] cmd_sh_q, cmd_sh_d;
    logic [7:0] addr_sh_q, addr_sh_d;
    logic [7:0] data_sh_q, data_sh_d;
    logic [7:0] addr_d, data_d;
    logic       wr_d, rd_d, ecsum_d, ecmd_d, eto_d;
    logic       expire;

    uart_gap_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_gap_timer (
        .s_clk  (s_clk),
        .s_rst  (s_rst),
        .clr    (rx_flag),
        .en     (state_q != ST_IDLE),
        .expire (expire)
    );

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        cmd_sh_d  = cmd_sh_q;
        addr_sh_d = addr_sh_q;
        data_sh_d = data_sh_q;
        addr_d    = cmd_addr;
        data_d    = cmd_data;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        ecsum_d   = 1'b0;
        ecmd_d    = 1'b0;
        eto_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_flag && rx_data == HEADER) begin
                    state_d = ST_CMD;
                    sum_d   = '0;
                end
            end
            ST_CMD: begin
                if (rx_flag) begin
                    cmd_sh_d = rx_data;
                    sum_d    = sum_q + rx_data;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_flag) begin
                    addr_sh_d = rx_data;
                    sum_d     = sum_q + rx_data;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_flag) begin
                    data_sh_d = rx_data;
                    sum_d     = sum_q + rx_data;
                    state_d   = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (rx_flag) begin
                    state_d = ST_IDLE;
                    if (rx_data != sum_q) begin
                        ecsum_d = 1'b1;
                    end else if (cmd_sh_q == CMD_WR || cmd_sh_q == CMD_RD) begin
                        wr_d   = (cmd_sh_q == CMD_WR);
                        rd_d   = (cmd_sh_q == CMD_RD);
                        addr_d = addr_sh_q;
                        data_d = data_sh_q;
                    end else begin
                        ecmd_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // expire is only raised without rx_flag, so it never races a response.
        if (expire) begin
            state_d = ST_IDLE;
            eto_d   = 1'b1;
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_q     <= ST_IDLE;
            sum_q       <= '0;
            cmd_sh_q    <= '0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            cmd_addr    <= '0;
            cmd_data    <= '0;
            cmd_wr      <= 1'b0;
            cmd_rd      <= 1'b0;
            err_csum    <= 1'b0;
            err_cmd     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cmd_sh_q    <= cmd_sh_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            cmd_addr    <= addr_d;
            cmd_data    <= data_d;
            cmd_wr      <= wr_d;
            cmd_rd      <= rd_d;
            err_csum    <= ecsum_d;
            err_cmd     <= ecmd_d;
            err_timeout <= eto_d;
        end
    end

endmodule
